lfsr_gen: RTL and testbench



---
 rtl/lfsr_gen.sv | 108 ++++++++++
 tb/tb_lfsr_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with runtime seed load,
// zero-state lock-up recovery and period measurement with a wrap pulse.
module lfsr_gen #(
    parameter int                 WIDTH = 7,
    parameter logic [WIDTH-1:0]   TAPS  = 7'b1000100,
    parameter logic [WIDTH-1:0]   SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int                 STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data_out,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_FIX = (SEED == '0) ? ONE : SEED;

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             pvalid_q, pvalid_d;

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] seed_fix;
    logic             cnt_sat;

    // Unrolled STEPS single shifts of the current state.
    always_comb begin
        stepped = state_q;
        for (int i = 0; i < STEPS; i++) begin
            stepped = {stepped[WIDTH-2:0], ^(stepped & TAPS)};
        end
    end

    assign seed_fix = (seed_in == '0) ? ONE : seed_in;
    // An all-ones counter means the measurement overflowed; no wrap is reported then.
    assign cnt_sat  = &cnt_q;

    // Next-state selection: load over en; nothing asserted holds everything.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        period_d = period_q;
        pvalid_d = pvalid_q;
        if (load) begin
            state_d  = seed_fix;
            start_d  = seed_fix;
            cnt_d    = '0;
            period_d = '0;
            pvalid_d = 1'b0;
        end else if (en) begin
            if (state_q == '0) begin
                // Lock-up recovery: reseed to 1 and restart the measurement from there.
                state_d = ONE;
                start_d = ONE;
                cnt_d   = '0;
            end else begin
                state_d = stepped;
                if (!cnt_sat) begin
                    if (stepped == start_q) begin
                        wrap_d   = 1'b1;
                        period_d = cnt_q + ONE;
                        pvalid_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEED_FIX;
            start_q  <= SEED_FIX;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            period_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign data_out     = state_q;
    assign bit_out      = state_q[WIDTH-1];
    assign wrap         = wrap_q;
    assign period       = period_q;
    assign period_valid = pvalid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default, TAPS=0 and STEPS=2 instances share stimulus.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seed_in = 7'h00;

    logic [6:0] d_data, d_period;
    logic       d_bit, d_wrap, d_valid;
    logic [6:0] z_data, z_period;
    logic       z_bit, z_wrap, z_valid;
    logic [6:0] s_data, s_period;
    logic       s_bit, s_wrap, s_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_gen u_def (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .data_out(d_data), .bit_out(d_bit), .wrap(d_wrap),
        .period(d_period), .period_valid(d_valid)
    );

    lfsr_gen #(.TAPS(7'b0000000)) u_t0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .data_out(z_data), .bit_out(z_bit), .wrap(z_wrap),
        .period(z_period), .period_valid(z_valid)
    );

    lfsr_gen #(.STEPS(2)) u_s2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .data_out(s_data), .bit_out(s_bit), .wrap(s_wrap),
        .period(s_period), .period_valid(s_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (d_data !== 7'h01 || d_wrap !== 1'b0 || d_period !== 7'h00 || d_valid !== 1'b0 || d_bit !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: data=%h wrap=%b period=%0d valid=%b bit=%b, expected 01 0 0 0 0",
                     d_data, d_wrap, d_period, d_valid, d_bit);
        end
    endtask

    task automatic test_sequence();
        logic [6:0] exp_seq [6] = '{7'h02, 7'h04, 7'h09, 7'h12, 7'h24, 7'h49};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (d_data !== exp_seq[i]) begin
                failures++;
                $display("FAIL seq_step%0d: data=%h expected %h", i + 1, d_data, exp_seq[i]);
            end
        end
        checks++;
        if (d_bit !== 1'b1) begin
            failures++;
            $display("FAIL bit_out_49: bit_out=%b expected 1", d_bit);
        end
        en = 1'b0;
        tick();
        checks++;
        if (d_data !== 7'h49 || d_wrap !== 1'b0) begin
            failures++;
            $display("FAIL hold_no_en: data=%h wrap=%b expected 49 0", d_data, d_wrap);
        end
    endtask

    task automatic test_period();
        int first_wrap = -1;
        int wraps = 0;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 254; c++) begin
            tick();
            if (d_wrap === 1'b1) begin
                wraps++;
                if (first_wrap < 0) first_wrap = c;
            end
            if (c == 126) begin
                checks++;
                if (d_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL valid_before_wrap: valid=%b expected 0", d_valid);
                end
            end
            if (c == 127) begin
                checks++;
                if (d_wrap !== 1'b1 || d_data !== 7'h01 || d_period !== 7'd127 || d_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL first_wrap: wrap=%b data=%h period=%0d valid=%b expected 1 01 127 1",
                             d_wrap, d_data, d_period, d_valid);
                end
            end
            if (c == 200) begin
                checks++;
                if (d_wrap !== 1'b0 || d_period !== 7'd127 || d_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL period_held: wrap=%b period=%0d valid=%b expected 0 127 1",
                             d_wrap, d_period, d_valid);
                end
            end
            if (c == 254) begin
                checks++;
                if (d_wrap !== 1'b1 || d_data !== 7'h01) begin
                    failures++;
                    $display("FAIL second_wrap: wrap=%b data=%h expected 1 01", d_wrap, d_data);
                end
            end
        end
        checks++;
        if (first_wrap !== 127 || wraps !== 2) begin
            failures++;
            $display("FAIL wrap_count: first=%0d count=%0d expected 127 2", first_wrap, wraps);
        end
        en = 1'b0;
        tick();
        checks++;
        if (d_wrap !== 1'b0) begin
            failures++;
            $display("FAIL wrap_clears: wrap=%b expected 0", d_wrap);
        end
    endtask

    task automatic test_load();
        int wrap_at = -1;
        load = 1'b1; seed_in = 7'h00;
        tick();
        checks++;
        if (d_data !== 7'h01 || d_valid !== 1'b0 || d_period !== 7'h00 || d_wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_zero: data=%h valid=%b period=%0d wrap=%b expected 01 0 0 0",
                     d_data, d_valid, d_period, d_wrap);
        end
        seed_in = 7'h55;
        tick();
        load = 1'b0;
        checks++;
        if (d_data !== 7'h55) begin
            failures++;
            $display("FAIL load_55: data=%h expected 55", d_data);
        end
        en = 1'b1;
        for (int c = 1; c <= 127; c++) begin
            tick();
            if (d_wrap === 1'b1 && wrap_at < 0) wrap_at = c;
        end
        en = 1'b0;
        checks++;
        if (wrap_at !== 127 || d_data !== 7'h55 || d_period !== 7'd127 || d_valid !== 1'b1) begin
            failures++;
            $display("FAIL load_55_wrap: at=%0d data=%h period=%0d valid=%b expected 127 55 127 1",
                     wrap_at, d_data, d_period, d_valid);
        end
    endtask

    task automatic test_lockup();
        do_reset();
        en = 1'b1;
        for (int c = 0; c < 7; c++) tick();
        checks++;
        if (z_data !== 7'h00) begin
            failures++;
            $display("FAIL taps0_reach_zero: data=%h expected 00", z_data);
        end
        tick();
        checks++;
        if (z_data !== 7'h01 || z_wrap !== 1'b0) begin
            failures++;
            $display("FAIL taps0_recover: data=%h wrap=%b expected 01 0", z_data, z_wrap);
        end
        tick();
        en = 1'b0;
        checks++;
        if (z_data !== 7'h02) begin
            failures++;
            $display("FAIL taps0_after_recover: data=%h expected 02", z_data);
        end
    endtask

    task automatic test_steps2();
        int wrap_at = -1;
        do_reset();
        en = 1'b1;
        tick();
        checks++;
        if (s_data !== 7'h04) begin
            failures++;
            $display("FAIL steps2_first: data=%h expected 04", s_data);
        end
        tick();
        checks++;
        if (s_data !== 7'h12) begin
            failures++;
            $display("FAIL steps2_second: data=%h expected 12", s_data);
        end
        for (int c = 3; c <= 127; c++) begin
            tick();
            if (s_wrap === 1'b1 && wrap_at < 0) wrap_at = c;
        end
        en = 1'b0;
        checks++;
        if (wrap_at !== 127 || s_period !== 7'd127 || s_valid !== 1'b1 || s_data !== 7'h01) begin
            failures++;
            $display("FAIL steps2_wrap: at=%0d period=%0d valid=%b data=%h expected 127 127 1 01",
                     wrap_at, s_period, s_valid, s_data);
        end
    endtask

    task automatic test_back_to_back();
        int wrap_at = -1;
        load = 1'b1; seed_in = 7'h40; en = 1'b0;
        tick();
        rst = 1'b1; load = 1'b1; en = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (d_data !== 7'h01) begin
            failures++;
            $display("FAIL rst_load_en: data=%h expected 01", d_data);
        end
        load = 1'b1; en = 1'b1; seed_in = 7'h03;
        tick();
        load = 1'b0;
        checks++;
        if (d_data !== 7'h03 || d_wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_beats_en: data=%h wrap=%b expected 03 0", d_data, d_wrap);
        end
        // Full measurement first so a valid period exists before the mid-run reset.
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 127 + 60; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (d_data !== 7'h01 || d_valid !== 1'b0 || d_period !== 7'h00 || d_wrap !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_measure: data=%h valid=%b period=%0d wrap=%b expected 01 0 0 0",
                     d_data, d_valid, d_period, d_wrap);
        end
        for (int c = 1; c <= 127; c++) begin
            tick();
            if (d_wrap === 1'b1 && wrap_at < 0) wrap_at = c;
        end
        en = 1'b0;
        checks++;
        if (wrap_at !== 127 || d_period !== 7'd127) begin
            failures++;
            $display("FAIL counter_restart: at=%0d period=%0d expected 127 127", wrap_at, d_period);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequence();
        test_period();
        test_load();
        test_lockup();
        test_steps2();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
